// File: rtl/regfile_wb_arbiter_if.sv
// One writeback requester channel: a register write offered under a valid/ready handshake.
// The requester drives the master side and the arbiter consumes the slave side.
interface regfile_wb_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          valid;
    logic [AW-1:0] regAddr;
    logic [DW-1:0] data;
    logic          ready;

    modport master (output valid, regAddr, data, input ready);
    modport slave  (input valid, regAddr, data, output ready);
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port controller: clears every register after reset, then round-robins the
// single write port between the ALU (req0) and load (req1) writeback requesters.
module regfile_wb_arbiter #(
    parameter int             NREGS       = 32,
    parameter int             AW          = 5,
    parameter int             DW          = 32,
    parameter bit             INIT_CLEAR  = 1'b1,
    parameter logic [DW-1:0]  INIT_VALUE  = '0,
    parameter bit             R0_WRITABLE = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    regfile_wb_arbiter_if.slave        req0,
    regfile_wb_arbiter_if.slave        req1,
    output logic                       RegWrite,
    output logic [AW-1:0]              WriteRegister,
    output logic [DW-1:0]              WriteData,
    output logic                       init_done
);
    typedef enum logic {INIT, RUN} state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wbReq_t;

    state_t        state;
    logic [AW-1:0] cnt;
    logic          rrPtr;
    logic          running;
    logic          grant0, grant1;
    logic          acc0, acc1;
    wbReq_t        sel;

    // Readies are gated by reset too, so nothing is offered while reset is held.
    assign running = (state == RUN) && !reset;

    always_comb begin
        grant0 = req0.valid && (!req1.valid || !rrPtr);
        grant1 = req1.valid && (!req0.valid ||  rrPtr);
    end

    assign req0.ready = running && grant0;
    assign req1.ready = running && grant1;
    assign acc0       = req0.valid && req0.ready;
    assign acc1       = req1.valid && req1.ready;
    assign init_done  = running;

    assign sel = acc1 ? wbReq_t'{addr: req1.regAddr, data: req1.data}
                      : wbReq_t'{addr: req0.regAddr, data: req0.data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= INIT_CLEAR ? INIT : RUN;
            cnt           <= '0;
            rrPtr         <= 1'b0;
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            case (state)
                INIT: begin
                    // Register 0 is cleared here even when it is not writable at run time.
                    RegWrite      <= 1'b1;
                    WriteRegister <= cnt;
                    WriteData     <= INIT_VALUE;
                    cnt           <= cnt + 1'b1;
                    if (cnt == AW'(NREGS - 1))
                        state <= RUN;
                end
                RUN: begin
                    if (acc0 || acc1) begin
                        RegWrite      <= R0_WRITABLE || (sel.addr != '0);
                        WriteRegister <= sel.addr;
                        WriteData     <= sel.data;
                        // Point at the other requester after every accept, contended or not.
                        rrPtr         <= acc0;
                    end else begin
                        RegWrite <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: default DUT, an R0-writable copy fed the same requests, and an INIT_CLEAR=0 copy.
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   nCmp = 0;
    int   nErr = 0;

    always #5 clk = ~clk;

    // shared requester stimulus for dutA/dutB, separate stimulus for dutC
    logic        v0, v1, cv0, cv1;
    logic [4:0]  r0, r1, cr0, cr1;
    logic [31:0] d0, d1, cd0, cd1;

    regfile_wb_arbiter_if #(.AW(5), .DW(32)) ifA0 (), ifA1 (), ifB0 (), ifB1 (), ifC0 (), ifC1 ();

    assign ifA0.valid = v0;  assign ifA0.regAddr = r0;  assign ifA0.data = d0;
    assign ifA1.valid = v1;  assign ifA1.regAddr = r1;  assign ifA1.data = d1;
    assign ifB0.valid = v0;  assign ifB0.regAddr = r0;  assign ifB0.data = d0;
    assign ifB1.valid = v1;  assign ifB1.regAddr = r1;  assign ifB1.data = d1;
    assign ifC0.valid = cv0; assign ifC0.regAddr = cr0; assign ifC0.data = cd0;
    assign ifC1.valid = cv1; assign ifC1.regAddr = cr1; assign ifC1.data = cd1;

    logic        aWe, bWe, cWe, aDone, bDone, cDone;
    logic [4:0]  aWr, bWr, cWr;
    logic [31:0] aWd, bWd, cWd;

    regfile_wb_arbiter dutA (
        .clk(clk), .reset(reset), .req0(ifA0.slave), .req1(ifA1.slave),
        .RegWrite(aWe), .WriteRegister(aWr), .WriteData(aWd), .init_done(aDone)
    );
    regfile_wb_arbiter #(.R0_WRITABLE(1'b1)) dutB (
        .clk(clk), .reset(reset), .req0(ifB0.slave), .req1(ifB1.slave),
        .RegWrite(bWe), .WriteRegister(bWr), .WriteData(bWd), .init_done(bDone)
    );
    regfile_wb_arbiter #(.INIT_CLEAR(1'b0)) dutC (
        .clk(clk), .reset(reset), .req0(ifC0.slave), .req1(ifC1.slave),
        .RegWrite(cWe), .WriteRegister(cWr), .WriteData(cWd), .init_done(cDone)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walks n init edges with both requesters pressing; they back off before the last init edge.
    task automatic initSeq(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk($sformatf("init%0d.we", i), {31'd0, aWe}, 32'd1);
            chk($sformatf("init%0d.wr", i), {27'd0, aWr}, i);
            chk($sformatf("init%0d.wd", i), aWd, 32'd0);
            chk($sformatf("init%0d.done", i), {31'd0, aDone}, (i == 31) ? 32'd1 : 32'd0);
            chk($sformatf("init%0d.rdy0", i), {31'd0, ifA0.ready}, 32'd0);
            chk($sformatf("init%0d.rdy1", i), {31'd0, ifA1.ready}, 32'd0);
            chk($sformatf("init%0d.bwr", i), {27'd0, bWr}, i);
            if (i == 30) begin
                v0 = 1'b0;
                v1 = 1'b0;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        v0 = 1'b1; r0 = 5'd2; d0 = 32'hAA;
        v1 = 1'b1; r1 = 5'd2; d1 = 32'hBB;
        cv0 = 1'b0; cr0 = '0; cd0 = '0;
        cv1 = 1'b0; cr1 = '0; cd1 = '0;

        // reset state
        repeat (3) tick();
        chk("rst.we",   {31'd0, aWe}, 32'd0);
        chk("rst.wr",   {27'd0, aWr}, 32'd0);
        chk("rst.wd",   aWd, 32'd0);
        chk("rst.done", {31'd0, aDone}, 32'd0);
        chk("rst.rdy0", {31'd0, ifA0.ready}, 32'd0);
        chk("rst.cDone", {31'd0, cDone}, 32'd0);
        reset = 1'b0;
        initSeq(32);

        // single write
        v0 = 1'b1; r0 = 5'd5; d0 = 32'hDEADBEEF;
        #1;
        chk("t2.rdy0", {31'd0, ifA0.ready}, 32'd1);
        chk("t2.rdy1", {31'd0, ifA1.ready}, 32'd0);
        tick();
        v0 = 1'b0;
        chk("t2.we", {31'd0, aWe}, 32'd1);
        chk("t2.wr", {27'd0, aWr}, 32'd5);
        chk("t2.wd", aWd, 32'hDEADBEEF);
        tick();
        chk("t2.weOff", {31'd0, aWe}, 32'd0);
        chk("t2.wrHold", {27'd0, aWr}, 32'd5);
        chk("t2.wdHold", aWd, 32'hDEADBEEF);

        // lone req1 write; pointer returns to favouring req0
        v1 = 1'b1; r1 = 5'd9; d1 = 32'h99;
        #1;
        chk("t2b.rdy1", {31'd0, ifA1.ready}, 32'd1);
        tick();
        v1 = 1'b0;
        chk("t2b.wr", {27'd0, aWr}, 32'd9);
        chk("t2b.wd", aWd, 32'h99);

        // continuous contention alternates 0,1,0,1
        v0 = 1'b1; r0 = 5'd3; d0 = 32'h11;
        v1 = 1'b1; r1 = 5'd4; d1 = 32'h22;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("t3.%0d.rdy0", k), {31'd0, ifA0.ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("t3.%0d.rdy1", k), {31'd0, ifA1.ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            chk($sformatf("t3.%0d.we", k), {31'd0, aWe}, 32'd1);
            chk($sformatf("t3.%0d.wr", k), {27'd0, aWr}, (k % 2 == 0) ? 32'd3 : 32'd4);
            chk($sformatf("t3.%0d.wd", k), aWd, (k % 2 == 0) ? 32'h11 : 32'h22);
        end
        v0 = 1'b0; v1 = 1'b0;
        tick();
        chk("t3.weOff", {31'd0, aWe}, 32'd0);

        // write to r0: dropped on dutA, performed on dutB
        v1 = 1'b1; r1 = 5'd0; d1 = 32'h55;
        #1;
        chk("t4.rdy1", {31'd0, ifA1.ready}, 32'd1);
        tick();
        v1 = 1'b0;
        chk("t4.aWe", {31'd0, aWe}, 32'd0);
        chk("t4.bWe", {31'd0, bWe}, 32'd1);
        chk("t4.bWr", {27'd0, bWr}, 32'd0);
        chk("t4.bWd", bWd, 32'h55);

        // reset pulse at init cycle 10
        reset = 1'b1; #1; reset = 1'b0;
        v0 = 1'b1; r0 = 5'd2; d0 = 32'hAA;
        v1 = 1'b1; r1 = 5'd2; d1 = 32'hBB;
        initSeq(10);
        reset = 1'b1;
        #1;
        chk("t5.midWe",   {31'd0, aWe}, 32'd0);
        chk("t5.midWr",   {27'd0, aWr}, 32'd0);
        chk("t5.midDone", {31'd0, aDone}, 32'd0);
        reset = 1'b0;
        initSeq(32);

        // reset with a RUN write on the outputs
        v0 = 1'b1; r0 = 5'd12; d0 = 32'h77;
        #1;
        chk("t5b.rdy0", {31'd0, ifA0.ready}, 32'd1);
        tick();
        v0 = 1'b0;
        chk("t5b.we", {31'd0, aWe}, 32'd1);
        reset = 1'b1;
        #1;
        chk("t5b.rstWe", {31'd0, aWe}, 32'd0);
        chk("t5b.rstWd", aWd, 32'd0);
        reset = 1'b0;
        initSeq(32);

        // INIT_CLEAR=0: request held across reset release is granted at once
        cv0 = 1'b1; cr0 = 5'd7; cd0 = 32'd1;
        reset = 1'b1;
        #1;
        chk("t6.rstRdy",  {31'd0, ifC0.ready}, 32'd0);
        chk("t6.rstDone", {31'd0, cDone}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("t6.rdy0", {31'd0, ifC0.ready}, 32'd1);
        chk("t6.rdy1", {31'd0, ifC1.ready}, 32'd0);
        chk("t6.done", {31'd0, cDone}, 32'd1);
        chk("t6.aDone", {31'd0, aDone}, 32'd0);
        tick();
        cv0 = 1'b0;
        chk("t6.we", {31'd0, cWe}, 32'd1);
        chk("t6.wr", {27'd0, cWr}, 32'd7);
        chk("t6.wd", cWd, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
